// File: rtl/cz_uartio.sv
// cz_uartio: UART peripheral on the CPU port bus.
// Four registers at BASE+0..3: TX push / RX data, STATUS (W1C OVR/FE), DIV, INTEN.
// TX FIFO feeding an 8N1 transmitter; 16x-oversampled 8N1 receiver sharing one tick.
// Optional feature: define CZ_UARTIO_RXFIFO_EN for a 2**FIFO_AW deep RX FIFO;
// otherwise the receiver stores into a single holding register.
module cz_uartio #(
  parameter logic [7:0]  BASE     = 8'h00,
  parameter int unsigned FIFO_AW  = 3,
  parameter logic [7:0]  DIV_INIT = 8'd0
) (
  input  logic       CLK,
  input  logic       xRESET_P,
  input  logic [7:0] xPORTID_P,
  input  logic [7:0] xOUTPORT_P,
  input  logic       xWSTROBE_P,
  input  logic       xWSTROBEK_P,
  input  logic       xRSTROBE_P,
  input  logic       xRXD_P,
  output logic [7:0] xINPORT_P,
  output logic       xINT_P,
  output logic       xTXD_P
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] PtrOne = 1;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} txStateE;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rxStateE;

  // Port decode
  logic       sel;
  logic [1:0] regAddr;
  logic       wrEn, wrData, wrStat, wrDiv, wrInten, rdData;

  assign sel     = (xPORTID_P[7:2] == BASE[7:2]);
  assign regAddr = xPORTID_P[1:0];
  assign wrEn    = sel & (xWSTROBE_P | xWSTROBEK_P);
  assign wrData  = wrEn & (regAddr == 2'd0);
  assign wrStat  = wrEn & (regAddr == 2'd1);
  assign wrDiv   = wrEn & (regAddr == 2'd2);
  assign wrInten = wrEn & (regAddr == 2'd3);
  assign rdData  = sel & xRSTROBE_P & (regAddr == 2'd0);

  // Baud tick: one pulse every divQ+1 clocks
  logic [7:0] divQ, divCntQ;
  logic       tick;

  assign tick = (divCntQ == divQ);

  // Divisor register and tick counter; a divisor write restarts the count
  always_ff @(posedge CLK) begin
    if (xRESET_P) begin
      divQ    <= DIV_INIT;
      divCntQ <= 8'd0;
    end else if (wrDiv) begin
      divQ    <= xOUTPORT_P;
      divCntQ <= 8'd0;
    end else if (tick) begin
      divCntQ <= 8'd0;
    end else begin
      divCntQ <= divCntQ + 8'd1;
    end
  end

  // TX FIFO
  logic [7:0]       txMem [Depth];
  logic [FIFO_AW:0] txWrPtrQ, txRdPtrQ;
  logic             txEmpty, txFull, txPush, txPop;

  assign txEmpty = (txWrPtrQ == txRdPtrQ);
  assign txFull  = (txWrPtrQ[FIFO_AW] != txRdPtrQ[FIFO_AW]) &&
                   (txWrPtrQ[FIFO_AW-1:0] == txRdPtrQ[FIFO_AW-1:0]);
  assign txPush  = wrData & ~txFull;

  // TX FIFO storage
  always_ff @(posedge CLK) begin
    if (txPush) txMem[txWrPtrQ[FIFO_AW-1:0]] <= xOUTPORT_P;
  end

  // TX FIFO pointers
  always_ff @(posedge CLK) begin
    if (xRESET_P) begin
      txWrPtrQ <= '0;
      txRdPtrQ <= '0;
    end else begin
      if (txPush) txWrPtrQ <= txWrPtrQ + PtrOne;
      if (txPop)  txRdPtrQ <= txRdPtrQ + PtrOne;
    end
  end

  // TX FSM
  txStateE    txStateQ, txStateD;
  logic [3:0] txSubQ, txSubD;
  logic [2:0] txBitQ, txBitD;
  logic [7:0] txShiftQ, txShiftD;
  logic       txdQ, txdD, txBusy;

  assign txBusy = (txStateQ != TxIdle);

  // TX state register
  always_ff @(posedge CLK) begin
    if (xRESET_P) begin
      txStateQ <= TxIdle;
      txSubQ   <= 4'd0;
      txBitQ   <= 3'd0;
      txShiftQ <= 8'd0;
      txdQ     <= 1'b1;
    end else begin
      txStateQ <= txStateD;
      txSubQ   <= txSubD;
      txBitQ   <= txBitD;
      txShiftQ <= txShiftD;
      txdQ     <= txdD;
    end
  end

  // TX next state: each frame slot lasts 16 ticks; STOP chains straight into the next START
  always_comb begin
    txStateD = txStateQ;
    txSubD   = txSubQ;
    txBitD   = txBitQ;
    txShiftD = txShiftQ;
    txPop    = 1'b0;
    unique case (txStateQ)
      TxIdle: begin
        if (tick && !txEmpty) begin
          txPop    = 1'b1;
          txShiftD = txMem[txRdPtrQ[FIFO_AW-1:0]];
          txSubD   = 4'd0;
          txStateD = TxStart;
        end
      end
      TxStart: begin
        if (tick) begin
          txSubD = txSubQ + 4'd1;
          if (txSubQ == 4'd15) begin
            txBitD   = 3'd0;
            txStateD = TxData;
          end
        end
      end
      TxData: begin
        if (tick) begin
          txSubD = txSubQ + 4'd1;
          if (txSubQ == 4'd15) begin
            txShiftD = {1'b0, txShiftQ[7:1]};
            txBitD   = txBitQ + 3'd1;
            if (txBitQ == 3'd7) txStateD = TxStop;
          end
        end
      end
      TxStop: begin
        if (tick) begin
          txSubD = txSubQ + 4'd1;
          if (txSubQ == 4'd15) begin
            if (!txEmpty) begin
              txPop    = 1'b1;
              txShiftD = txMem[txRdPtrQ[FIFO_AW-1:0]];
              txStateD = TxStart;
            end else begin
              txStateD = TxIdle;
            end
          end
        end
      end
      default: txStateD = TxIdle;
    endcase
    unique case (txStateD)
      TxStart: txdD = 1'b0;
      TxData:  txdD = txShiftD[0];
      default: txdD = 1'b1;
    endcase
  end

  assign xTXD_P = txdQ;

  // RX synchroniser and FSM
  logic [1:0] rxSyncQ;
  logic       rxS;
  rxStateE    rxStateQ, rxStateD;
  logic [3:0] rxSubQ, rxSubD;
  logic [2:0] rxBitQ, rxBitD;
  logic [7:0] rxShiftQ, rxShiftD;
  logic       rxStore, feSet;

  assign rxS = rxSyncQ[1];

  // RX synchroniser and state register
  always_ff @(posedge CLK) begin
    if (xRESET_P) begin
      rxSyncQ  <= 2'b11;
      rxStateQ <= RxIdle;
      rxSubQ   <= 4'd0;
      rxBitQ   <= 3'd0;
      rxShiftQ <= 8'd0;
    end else begin
      rxSyncQ  <= {rxSyncQ[0], xRXD_P};
      rxStateQ <= rxStateD;
      rxSubQ   <= rxSubD;
      rxBitQ   <= rxBitD;
      rxShiftQ <= rxShiftD;
    end
  end

  // RX next state: sample at tick 8 of each bit; leave STOP after its sample to resync early
  always_comb begin
    rxStateD = rxStateQ;
    rxSubD   = rxSubQ;
    rxBitD   = rxBitQ;
    rxShiftD = rxShiftQ;
    rxStore  = 1'b0;
    feSet    = 1'b0;
    unique case (rxStateQ)
      RxIdle: begin
        if (!rxS) begin
          rxSubD   = 4'd0;
          rxStateD = RxStart;
        end
      end
      RxStart: begin
        if (tick) begin
          rxSubD = rxSubQ + 4'd1;
          if (rxSubQ == 4'd7 && rxS) begin
            rxStateD = RxIdle;
          end else if (rxSubQ == 4'd15) begin
            rxBitD   = 3'd0;
            rxStateD = RxData;
          end
        end
      end
      RxData: begin
        if (tick) begin
          rxSubD = rxSubQ + 4'd1;
          if (rxSubQ == 4'd7) rxShiftD = {rxS, rxShiftQ[7:1]};
          if (rxSubQ == 4'd15) begin
            rxBitD = rxBitQ + 3'd1;
            if (rxBitQ == 3'd7) rxStateD = RxStop;
          end
        end
      end
      RxStop: begin
        if (tick) begin
          rxSubD = rxSubQ + 4'd1;
          if (rxSubQ == 4'd7) begin
            rxStore  = 1'b1;
            feSet    = ~rxS;
            rxStateD = RxIdle;
          end
        end
      end
      default: rxStateD = RxIdle;
    endcase
  end

  // RX buffer; a CPU pop in the store cycle frees room first
  logic       rxAvail, rxFull, rxPop, rxPush, ovrSet;
  logic [7:0] rxHead;

  assign rxPop  = rdData & rxAvail;
  assign rxPush = rxStore & (~rxFull | rxPop);
  assign ovrSet = rxStore & rxFull & ~rxPop;

`ifdef CZ_UARTIO_RXFIFO_EN
  logic [7:0]       rxMem [Depth];
  logic [FIFO_AW:0] rxWrPtrQ, rxRdPtrQ;

  assign rxAvail = (rxWrPtrQ != rxRdPtrQ);
  assign rxFull  = (rxWrPtrQ[FIFO_AW] != rxRdPtrQ[FIFO_AW]) &&
                   (rxWrPtrQ[FIFO_AW-1:0] == rxRdPtrQ[FIFO_AW-1:0]);
  assign rxHead  = rxMem[rxRdPtrQ[FIFO_AW-1:0]];

  // RX FIFO storage
  always_ff @(posedge CLK) begin
    if (rxPush) rxMem[rxWrPtrQ[FIFO_AW-1:0]] <= rxShiftQ;
  end

  // RX FIFO pointers
  always_ff @(posedge CLK) begin
    if (xRESET_P) begin
      rxWrPtrQ <= '0;
      rxRdPtrQ <= '0;
    end else begin
      if (rxPush) rxWrPtrQ <= rxWrPtrQ + PtrOne;
      if (rxPop)  rxRdPtrQ <= rxRdPtrQ + PtrOne;
    end
  end
`else
  logic [7:0] rxHoldQ;
  logic       rxValidQ;

  assign rxAvail = rxValidQ;
  assign rxFull  = rxValidQ;
  assign rxHead  = rxHoldQ;

  // Single holding register; a store overrides a simultaneous pop's clear
  always_ff @(posedge CLK) begin
    if (xRESET_P) begin
      rxHoldQ  <= 8'd0;
      rxValidQ <= 1'b0;
    end else if (rxPush) begin
      rxHoldQ  <= rxShiftQ;
      rxValidQ <= 1'b1;
    end else if (rxPop) begin
      rxValidQ <= 1'b0;
    end
  end
`endif

  // Sticky error flags, write-1-to-clear, set has priority
  logic ovrQ, feQ;
  always_ff @(posedge CLK) begin
    if (xRESET_P) begin
      ovrQ <= 1'b0;
      feQ  <= 1'b0;
    end else begin
      if (ovrSet)                        ovrQ <= 1'b1;
      else if (wrStat && xOUTPORT_P[4])  ovrQ <= 1'b0;
      if (feSet)                         feQ  <= 1'b1;
      else if (wrStat && xOUTPORT_P[5])  feQ  <= 1'b0;
    end
  end

  // Interrupt enable, interrupt and read-data registers
  logic [1:0] intenQ;
  logic       intQ;
  logic [7:0] inportQ, inportD, status;

  assign status = {intQ, txBusy, feQ, ovrQ, rxFull, rxAvail, txFull, txEmpty};

  always_ff @(posedge CLK) begin
    if (xRESET_P) begin
      intenQ  <= 2'b00;
      intQ    <= 1'b0;
      inportQ <= 8'h00;
    end else begin
      if (wrInten) intenQ <= xOUTPORT_P[1:0];
      intQ    <= (intenQ[0] & rxAvail) | (intenQ[1] & txEmpty & ~txBusy);
      inportQ <= inportD;
    end
  end

  // Read mux; the RX head shown here is the byte a same-cycle strobe pops
  always_comb begin
    inportD = 8'h00;
    if (sel) begin
      unique case (regAddr)
        2'd0:    inportD = rxAvail ? rxHead : 8'h00;
        2'd1:    inportD = status;
        2'd2:    inportD = divQ;
        default: inportD = {6'b000000, intenQ};
      endcase
    end
  end

  assign xINPORT_P = inportQ;
  assign xINT_P    = intQ;

endmodule

// File: tb/tb_cz_uartio.sv
// Scoreboard bench for cz_uartio: TX frames decoded off the line and RX pops are checked
// by monitor processes against queues filled when stimulus is issued.
`timescale 1ns/1ps
module tb_cz_uartio;

  localparam logic [7:0] Base  = 8'h10;
  localparam int         Depth = 8;
`ifdef CZ_UARTIO_RXFIFO_EN
  localparam int         RxCap = Depth;
`else
  localparam int         RxCap = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] portId, outPort, inPort;
  logic       wStrobe, wStrobeK, rStrobe, rxd, intr, txd;

  always #5 clk = ~clk;

  cz_uartio #(
    .BASE    (Base),
    .FIFO_AW (3),
    .DIV_INIT(8'd0)
  ) dut (
    .CLK        (clk),
    .xRESET_P   (rst),
    .xPORTID_P  (portId),
    .xOUTPORT_P (outPort),
    .xWSTROBE_P (wStrobe),
    .xWSTROBEK_P(wStrobeK),
    .xRSTROBE_P (rStrobe),
    .xRXD_P     (rxd),
    .xINPORT_P  (inPort),
    .xINT_P     (intr),
    .xTXD_P     (txd)
  );

  int           total = 0;
  int           bad = 0;
  byte unsigned txExp[$];
  byte unsigned rxModel[$];
  int           divModel = 0;
  logic         expOvr = 1'b0;
  logic         expFe = 1'b0;
  logic [1:0]   intenModel = 2'b00;
  bit           txMonEn = 1'b1;
  bit           txMonBusy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wrReg(input logic [1:0] a, input logic [7:0] d, input bit useK);
    @(negedge clk);
    portId  = Base | {6'b000000, a};
    outPort = d;
    if (useK) wStrobeK = 1'b1;
    else      wStrobe  = 1'b1;
    @(negedge clk);
    wStrobe  = 1'b0;
    wStrobeK = 1'b0;
  endtask

  task automatic rdAbs(input logic [7:0] addr, output logic [7:0] d);
    @(negedge clk);
    portId = addr;
    @(posedge clk);
    #1 d = inPort;
  endtask

  task automatic rdReg(input logic [1:0] a, output logic [7:0] d);
    rdAbs(Base | {6'b000000, a}, d);
  endtask

  task automatic popRx();
    @(negedge clk);
    portId  = Base;
    rStrobe = 1'b1;
    @(negedge clk);
    rStrobe = 1'b0;
  endtask

  task automatic setDiv(input int d);
    wrReg(2'd2, 8'(d), 1'b0);
    divModel = d;
  endtask

  // Status expected from the model; valid only while the transmitter is idle
  task automatic checkStatus(input string name);
    logic [7:0] s;
    logic [7:0] e;
    logic       ie;
    ie = (intenModel[0] && rxModel.size() > 0) || intenModel[1];
    e  = {ie, 1'b0, expFe, expOvr, rxModel.size() == RxCap, rxModel.size() > 0, 1'b0, 1'b1};
    rdReg(2'd1, s);
    check(name, s, e);
  endtask

  // Drive one 8N1 frame; a bad stop bit is held low past its centre then released
  task automatic sendRx(input logic [7:0] b, input bit stopOk);
    int bitClk;
    bitClk = 16 * (divModel + 1);
    @(negedge clk);
    rxd = 1'b0;
    repeat (bitClk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (bitClk) @(negedge clk);
    end
    if (stopOk) begin
      rxd = 1'b1;
      repeat (bitClk) @(negedge clk);
    end else begin
      rxd = 1'b0;
      repeat (bitClk * 12 / 16) @(negedge clk);
      rxd = 1'b1;
      repeat (bitClk * 4 / 16) @(negedge clk);
    end
    repeat (bitClk) @(negedge clk);
    if (!stopOk) expFe = 1'b1;
    if (rxModel.size() < RxCap) rxModel.push_back(b);
    else expOvr = 1'b1;
  endtask

  task automatic waitTxIdle();
    int n;
    n = 0;
    while ((txExp.size() != 0 || txMonBusy) && n < 40000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 40000) begin
      total++;
      bad++;
      $display("FAIL tx_drain_timeout: got %0d frames pending expected 0", txExp.size());
    end
    repeat (16 * (divModel + 1)) @(posedge clk);
  endtask

  // TX monitor: decode each frame at bit centres and compare against the scoreboard
  initial begin : txMon
    logic [7:0] b;
    logic       startOk;
    int         bc;
    forever begin
      @(negedge txd);
      txMonBusy = 1'b1;
      bc = 16 * (divModel + 1);
      repeat (bc / 2) @(posedge clk);
      #1 startOk = (txd == 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (bc) @(posedge clk);
        #1 b[i] = txd;
      end
      repeat (bc) @(posedge clk);
      #1;
      if (txMonEn) begin
        check("tx_start_bit", startOk, 1);
        check("tx_stop_bit", txd, 1);
        if (txExp.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_unexpected_frame: got %0h expected no frame", b);
        end else begin
          check("tx_data", b, txExp.pop_front());
        end
      end
      txMonBusy = 1'b0;
    end
  end

  // RX monitor: every data-register pop must return the model's oldest byte, or 0 when empty
  initial begin : rxMon
    forever begin
      @(posedge clk);
      if (rStrobe && portId == Base) begin
        #1;
        if (rxModel.size() > 0) check("rx_data", inPort, rxModel.pop_front());
        else                    check("rx_empty_pop", inPort, 0);
      end
    end
  end

  initial begin : watchdog
    #800us;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0]   r;
    int           n, lowLen, busyLen, cnt;
    byte unsigned bb[$];

    rst = 1'b1;
    portId = 8'h00;
    outPort = 8'h00;
    wStrobe = 1'b0;
    wStrobeK = 1'b0;
    rStrobe = 1'b0;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_txd", txd, 1);
    check("reset_inport", inPort, 0);
    check("reset_int", intr, 0);
    @(negedge clk);
    rst = 1'b0;

    checkStatus("reset_status");
    rdReg(2'd2, r);
    check("reset_div", r, 0);
    rdReg(2'd3, r);
    check("reset_inten", r, 0);
    rdAbs(8'h20, r);
    check("undecoded_read", r, 0);

    // Constant strobe decodes like the register strobe
    wrReg(2'd2, 8'h5A, 1'b1);
    rdReg(2'd2, r);
    check("div_k_write", r, 8'h5A);
    setDiv(0);

    // 0xA5 at DIV=0: start bit width and busy duration
    txExp.push_back(8'hA5);
    wrReg(2'd0, 8'hA5, 1'b0);
    portId = Base | 8'h01;
    n = 0;
    while (txd !== 1'b0 && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    check("a5_start_seen", txd, 0);
    lowLen = 0;
    busyLen = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (lowLen == 0 && txd === 1'b1) lowLen = k;
      if (busyLen == 0 && inPort[6] === 1'b0) busyLen = k;
    end
    check("a5_start_len", lowLen, 16);
    // read data lags state by one clock
    check("a5_busy_clocks", busyLen - 1, 160);
    waitTxIdle();

    // Back-to-back burst: shifter plus FIFO absorb depth+1 bytes, the rest drop
    bb.delete();
    for (int i = 0; i < Depth + 2; i++) bb.push_back(8'($urandom));
    @(negedge clk);
    for (int i = 0; i <= Depth; i++) begin
      portId  = Base;
      outPort = bb[i];
      wStrobe = 1'b1;
      txExp.push_back(bb[i]);
      @(negedge clk);
    end
    wStrobe = 1'b0;
    rdReg(2'd1, r);
    check("burst_full", r[1], 1);
    check("burst_not_empty", r[0], 0);
    wrReg(2'd0, bb[Depth+1], 1'b0);
    rdReg(2'd1, r);
    check("burst_still_full", r[1], 1);
    waitTxIdle();

    // Random divisors and short bursts
    for (int round = 0; round < 4; round++) begin
      setDiv($urandom_range(0, 2));
      cnt = $urandom_range(1, 3);
      for (int i = 0; i < cnt; i++) begin
        r = 8'($urandom);
        txExp.push_back(r);
        wrReg(2'd0, r, 1'b0);
      end
      waitTxIdle();
    end
    checkStatus("tx_idle_status");

    // Receive 0x3C at DIV=3
    setDiv(3);
    sendRx(8'h3C, 1'b1);
    checkStatus("rx_3c_status");
    popRx();
    checkStatus("rx_3c_after_pop");

    // Random receive bytes at random divisors
    for (int i = 0; i < 3; i++) begin
      setDiv($urandom_range(0, 3));
      sendRx(8'($urandom), 1'b1);
      checkStatus("rx_rand_status");
      popRx();
    end

    // Framing error: byte kept, FE sticky until W1C
    setDiv(1);
    sendRx(8'($urandom), 1'b0);
    checkStatus("fe_set_status");
    popRx();
    wrReg(2'd1, 8'h20, 1'b0);
    expFe = 1'b0;
    checkStatus("fe_cleared_status");

    // Overrun: fill the buffer, one more byte is dropped and OVR set
    setDiv(0);
    for (int i = 0; i < RxCap + 1; i++) sendRx(8'($urandom), 1'b1);
    checkStatus("ovr_set_status");
    for (int i = 0; i < RxCap; i++) popRx();
    wrReg(2'd1, 8'h10, 1'b0);
    expOvr = 1'b0;
    checkStatus("ovr_cleared_status");

    // Pop in the store cycle of a frame arriving into a full buffer: no overrun.
    // At DIV=0 the stop sample lands on the 155th rising edge after the start bit.
    for (int i = 0; i < RxCap; i++) sendRx(8'($urandom), 1'b1);
    fork
      sendRx(8'($urandom), 1'b1);
      begin
        @(negedge clk);
        repeat (154) @(posedge clk);
        @(negedge clk);
        portId  = Base;
        rStrobe = 1'b1;
        @(negedge clk);
        rStrobe = 1'b0;
      end
    join
    checkStatus("pop_store_same_cycle_status");
    for (int i = 0; i < RxCap; i++) popRx();

    // Pop from an empty buffer returns 0
    popRx();
    checkStatus("empty_pop_status");

    // RX-available interrupt
    wrReg(2'd3, 8'h01, 1'b0);
    intenModel = 2'b01;
    repeat (2) @(posedge clk);
    #1 check("int_rx_idle", intr, 0);
    sendRx(8'($urandom), 1'b1);
    #1 check("int_rx_avail", intr, 1);
    popRx();
    @(posedge clk);
    #1 check("int_rx_after_pop", intr, 0);

    // TX-idle interrupt; upper INTEN bits read back as 0
    wrReg(2'd3, 8'hFE, 1'b0);
    intenModel = 2'b10;
    rdReg(2'd3, r);
    check("inten_readback", r, 8'h02);
    @(posedge clk);
    #1 check("int_tx_idle", intr, 1);
    wrReg(2'd3, 8'h00, 1'b0);
    intenModel = 2'b00;
    repeat (2) @(posedge clk);
    #1 check("int_disabled", intr, 0);

    // Reset in the middle of a frame
    txMonEn = 1'b0;
    wrReg(2'd0, 8'h00, 1'b0);
    repeat (40) @(posedge clk);
    #1 check("midtx_line_low", txd, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check("midtx_reset_txd", txd, 1);
    @(negedge clk);
    rst = 1'b0;
    divModel = 0;
    intenModel = 2'b00;
    expOvr = 1'b0;
    expFe = 1'b0;
    rxModel.delete();
    repeat (200) @(posedge clk);
    txMonEn = 1'b1;
    checkStatus("post_reset_status");
    txExp.push_back(8'h5C);
    wrReg(2'd0, 8'h5C, 1'b0);
    waitTxIdle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
